// File: rtl/nios2_debug_scan_master_if.sv
// Command/response bundle for the Nios II debug scan master.
// The scan master is the slave of this bus; the host is the master.
interface nios2_debug_scan_master_if #(
  parameter int SR_WIDTH = 38,
  parameter int IR_WIDTH = 2
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [SR_WIDTH-1:0] cmd_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [SR_WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_ir, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/nios2_debug_scan_master.sv
// Virtual-JTAG scan initiator for the Nios II debug slave.
// Runs UIR/CDR/SDR/UDR/RTI with a divided tck, returns the captured DR.
module nios2_debug_scan_master #(
  parameter int SR_WIDTH   = 38,
  parameter int IR_WIDTH   = 2,
  parameter int TCK_DIV    = 2,
  parameter int RTI_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  nios2_debug_scan_master_if.slave bus,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  localparam int DW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int BW = $clog2(SR_WIDTH + 1);
  localparam int RW = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TCK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(SR_WIDTH);
  localparam logic [RW-1:0] RTI_LAST = RW'(RTI_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, UIR, CDR, SDR, UDR, RTI, RSP
  } state_t;

  state_t              state;
  logic [DW-1:0]       div_cnt;
  logic                phase;
  logic [BW-1:0]       bit_cnt;
  logic [RW-1:0]       rti_cnt;
  logic [SR_WIDTH-1:0] shreg;
  logic                cmd_ready;
  logic                rsp_valid;
  logic                half_end;
  logic                rise;
  logic                per_end;
  logic                scan;

  assign half_end = (div_cnt == DIV_LAST);
  assign rise     = half_end & ~phase;
  assign per_end  = half_end & phase;
  assign scan     = (state != IDLE) && (state != RSP);

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = shreg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      div_cnt        <= '0;
      phase          <= 1'b0;
      bit_cnt        <= '0;
      rti_cnt        <= '0;
      shreg          <= '0;
      cmd_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      tck            <= 1'b0;
      tdi            <= 1'b0;
      ir_in          <= '0;
      vs_uir         <= 1'b0;
      vs_cdr         <= 1'b0;
      vs_sdr         <= 1'b0;
      vs_udr         <= 1'b0;
      jtag_state_rti <= 1'b0;
    end else begin
      // phase 0 is the tck-low half, phase 1 the tck-high half
      if (scan) begin
        if (half_end) begin
          div_cnt <= '0;
          phase   <= ~phase;
          tck     <= ~phase;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
      if (state == SDR && rise) begin
        shreg   <= {tdo, shreg[SR_WIDTH-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            ir_in     <= bus.cmd_ir;
            shreg     <= bus.cmd_data;
            cmd_ready <= 1'b0;
            div_cnt   <= '0;
            phase     <= 1'b0;
            vs_uir    <= 1'b1;
            state     <= UIR;
          end
        end
        UIR: begin
          if (per_end) begin
            vs_uir <= 1'b0;
            vs_cdr <= 1'b1;
            state  <= CDR;
          end
        end
        CDR: begin
          if (per_end) begin
            vs_cdr  <= 1'b0;
            vs_sdr  <= 1'b1;
            tdi     <= shreg[0];
            bit_cnt <= '0;
            state   <= SDR;
          end
        end
        SDR: begin
          // bit_cnt already counts this period's shift at its end
          if (per_end) begin
            if (bit_cnt == BIT_LAST) begin
              vs_sdr <= 1'b0;
              tdi    <= 1'b0;
              vs_udr <= 1'b1;
              state  <= UDR;
            end else begin
              tdi <= shreg[0];
            end
          end
        end
        UDR: begin
          if (per_end) begin
            vs_udr         <= 1'b0;
            jtag_state_rti <= 1'b1;
            rti_cnt        <= '0;
            state          <= RTI;
          end
        end
        RTI: begin
          if (per_end) begin
            if (rti_cnt == RTI_LAST) begin
              jtag_state_rti <= 1'b0;
              rsp_valid      <= 1'b1;
              state          <= RSP;
            end else begin
              rti_cnt <= rti_cnt + 1'b1;
            end
          end
        end
        RSP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
